// File: rtl/decoder_3x8_stream_if.sv
// Handshake bundle for the streaming 3-to-8 decoder.
// Input side: in_valid/in_code/in_ready. Output side: out_valid/out_ready/out_onehot.
// The slave modport is the decoder; the master modport is its environment,
// which supplies codes upstream and consumes words downstream.
interface decoder_3x8_stream_if;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_onehot;

    modport slave (
        input  in_valid,
        input  in_code,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_onehot
    );

    modport master (
        output in_valid,
        output in_code,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_onehot
    );
endinterface

// File: rtl/decoder_3x8_stream.sv
// Streaming 3-to-8 decoder.
// Codes enter through a small FIFO. The head code is decoded combinationally
// onto out_onehot, so a word is presented one cycle after it is pushed into an
// empty queue. in_ready depends only on en and the current occupancy. It does
// not look ahead at a same-cycle pop, so a full queue refuses a push even while
// it is draining.
// seen accumulates every delivered word and xfer_cnt counts deliveries mod 256.
module decoder_3x8_stream #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr_seen,
    decoder_3x8_stream_if.slave        bus,
    output logic [7:0]                 seen,
    output logic [7:0]                 xfer_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [2:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_seen;
    logic [7:0]    r_xfer_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head_onehot;
    logic [7:0]    w_seen_next;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid & bus.in_ready;
    assign w_pop   = ~w_empty & bus.out_ready;

    assign bus.in_ready   = en & ~w_full;
    assign bus.out_valid  = ~w_empty;
    assign bus.out_onehot = w_empty ? 8'h00 : w_head_onehot;

    assign seen     = r_seen;
    assign xfer_cnt = r_xfer_cnt;

    // Decode the oldest queued code into its one-hot word.
    always_comb begin
        w_head_onehot = 8'h01 << r_mem[r_rd_ptr];
    end

    // Next value of the sticky word history.
    // A word delivered in the same cycle as a clear is kept.
    always_comb begin
        w_seen_next = (clr_seen ? 8'h00 : r_seen) | (w_pop ? w_head_onehot : 8'h00);
    end

    // Code storage. Stale entries are unreachable once the counters reset,
    // so the array itself has no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_code;
        end
    end

    // Queue pointers and occupancy. Power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Delivery statistics: sticky seen mask and handshake counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen     <= 8'h00;
            r_xfer_cnt <= 8'h00;
        end else begin
            r_seen <= w_seen_next;
            if (w_pop) begin
                r_xfer_cnt <= r_xfer_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_decoder_3x8_stream.sv
// Directed bench for decoder_3x8_stream with DEPTH=2.
// Inputs change 1 time unit after a rising edge.
// Outputs are sampled after a further settle delay.
module tb_decoder_3x8_stream;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr_seen;
    logic [7:0] seen;
    logic [7:0] xfer_cnt;

    int n_checks;
    int n_errors;

    decoder_3x8_stream_if bus ();

    decoder_3x8_stream #(.DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr_seen (clr_seen),
        .bus      (bus.slave),
        .seen     (seen),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        en = 1'b1;
        clr_seen = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_code = 3'd0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_onehot", 32'(bus.out_onehot), 32'h00);
        chk("rst_seen", 32'(seen), 32'h00);
        chk("rst_xfer", 32'(xfer_cnt), 32'h00);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        #20;
        rst_n = 1'b1;

        // Single code through an always-ready sink.
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_code = 3'd5;
        tick();
        bus.in_valid = 1'b0;
        settle();
        chk("s1_valid", 32'(bus.out_valid), 32'h1);
        chk("s1_onehot", 32'(bus.out_onehot), 32'h20);
        tick();
        settle();
        chk("s1_valid_after", 32'(bus.out_valid), 32'h0);
        chk("s1_onehot_idle", 32'(bus.out_onehot), 32'h00);
        chk("s1_seen", 32'(seen), 32'h20);
        chk("s1_xfer", 32'(xfer_cnt), 32'h01);

        // Fill to full with the sink stalled; the third code must wait.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_code = 3'd0;
        tick();
        bus.in_code = 3'd7;
        tick();
        bus.in_code = 3'd3;
        settle();
        chk("s2_full_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        settle();
        chk("s2_stall_onehot", 32'(bus.out_onehot), 32'h01);
        chk("s2_stall_valid", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        settle();
        chk("s2_word0", 32'(bus.out_onehot), 32'h01);
        chk("s2_full_pop_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        settle();
        chk("s2_word1", 32'(bus.out_onehot), 32'h80);
        chk("s2_reopen_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        settle();
        chk("s2_word2", 32'(bus.out_onehot), 32'h08);
        tick();
        settle();
        chk("s2_drained", 32'(bus.out_valid), 32'h0);
        chk("s2_xfer", 32'(xfer_cnt), 32'h04);
        chk("s2_seen", 32'(seen), 32'hA9);

        // Simultaneous push and pop at occupancy 1.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_code = 3'd6;
        tick();
        bus.in_code = 3'd2;
        bus.out_ready = 1'b1;
        settle();
        chk("s3_head", 32'(bus.out_onehot), 32'h40);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        settle();
        chk("s3_valid", 32'(bus.out_valid), 32'h1);
        chk("s3_next_word", 32'(bus.out_onehot), 32'h04);
        chk("s3_occ1_in_ready", 32'(bus.in_ready), 32'h1);
        bus.out_ready = 1'b1;
        tick();
        settle();
        chk("s3_empty", 32'(bus.out_valid), 32'h0);
        chk("s3_xfer", 32'(xfer_cnt), 32'h06);

        // en=0 drains queued words but accepts nothing.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_code = 3'd1;
        tick();
        bus.in_code = 3'd2;
        tick();
        en = 1'b0;
        bus.in_code = 3'd7;
        bus.out_ready = 1'b1;
        settle();
        chk("s4_in_ready0", 32'(bus.in_ready), 32'h0);
        chk("s4_word0", 32'(bus.out_onehot), 32'h02);
        tick();
        settle();
        chk("s4_in_ready1", 32'(bus.in_ready), 32'h0);
        chk("s4_word1", 32'(bus.out_onehot), 32'h04);
        tick();
        settle();
        chk("s4_in_ready2", 32'(bus.in_ready), 32'h0);
        chk("s4_drained", 32'(bus.out_valid), 32'h0);
        tick();
        settle();
        chk("s4_no_push", 32'(bus.out_valid), 32'h0);
        chk("s4_xfer", 32'(xfer_cnt), 32'h08);
        bus.in_valid = 1'b0;
        en = 1'b1;

        // Asynchronous reset with two words queued.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_code = 3'd3;
        tick();
        bus.in_code = 3'd6;
        tick();
        bus.in_valid = 1'b0;
        settle();
        chk("s6_pre_valid", 32'(bus.out_valid), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("s6_rst_onehot", 32'(bus.out_onehot), 32'h00);
        chk("s6_rst_seen", 32'(seen), 32'h00);
        chk("s6_rst_xfer", 32'(xfer_cnt), 32'h00);
        chk("s6_rst_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s6_no_stale_valid", 32'(bus.out_valid), 32'h0);
        end
        chk("s6_no_stale_xfer", 32'(xfer_cnt), 32'h00);

        // 256 deliveries of code 1: counter wraps.
        bus.in_valid = 1'b1;
        bus.in_code = 3'd1;
        tick();
        for (int i = 0; i < 255; i++) begin
            tick();
        end
        bus.in_valid = 1'b0;
        settle();
        chk("s5_xfer_ff", 32'(xfer_cnt), 32'hFF);
        tick();
        settle();
        chk("s5_xfer_wrap", 32'(xfer_cnt), 32'h00);
        chk("s5_seen", 32'(seen), 32'h02);
        chk("s5_empty", 32'(bus.out_valid), 32'h0);

        // Clear coinciding with a delivery of code 4 keeps that word.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_code = 3'd4;
        tick();
        bus.in_valid = 1'b0;
        clr_seen = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        clr_seen = 1'b0;
        settle();
        chk("s5_clr_pop_seen", 32'(seen), 32'h10);
        chk("s5_clr_pop_xfer", 32'(xfer_cnt), 32'h01);

        // Clear with no delivery empties the history.
        clr_seen = 1'b1;
        tick();
        clr_seen = 1'b0;
        settle();
        chk("s5_clr_seen", 32'(seen), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
